// File: rtl/mac_cfg_slave_if.sv
// Avalon-MM register-bus bundle between the MAC init master
// and the MAC control register bank.
interface mac_cfg_slave_if;
   logic [7:0]  address;
   logic        write;
   logic        read;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;

   modport master (
      output address, write, read, writedata,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, write, read, writedata,
      output readdata, waitrequest
   );
endinterface

// File: rtl/mac_cfg_slave.sv
// MAC control register bank: Avalon-MM slave with programmable
// waitrequest stall, exported config fields and sticky init_done.
module mac_cfg_slave #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [15:0] FRM_LEN_RST = 16'd1518,
   parameter logic [31:0] REV_ID      = 32'h0000_0901
) (
   input  logic          clk,
   input  logic          reset,
   mac_cfg_slave_if.slave bus,
   output logic [31:0]   cfg_command,
   output logic [15:0]   cfg_frm_length,
   output logic [3:0]    cfg_fifo_thr,
   output logic [2:0]    cfg_pcs_ctrl,
   output logic          cfg_update,
   output logic          init_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

   localparam logic [7:0] A_REV = 8'h00;
   localparam logic [7:0] A_CMD = 8'h02;
   localparam logic [7:0] A_FRM = 8'h05;
   localparam logic [7:0] A_THR = 8'h0E;
   localparam logic [7:0] A_PCS = 8'h94;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        w_latch;
   logic        w_wait;
   logic        w_req;

   logic [7:0]  r_addr;
   logic [31:0] r_wdata;
   logic        r_op_wr;

   logic [31:0] r_cmd;
   logic [15:0] r_frm;
   logic [3:0]  r_thr;
   logic [2:0]  r_pcs;
   logic [2:0]  r_flags;
   logic        r_upd;
   logic        r_init;

   logic        w_commit;
   logic        w_mapped;
   logic [31:0] w_rmux;

   assign w_req = bus.write | bus.read;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_latch   = 1'b0;
      w_wait    = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_latch   = 1'b1;
               w_cnt_nxt = LP_WAIT;
               w_next    = (LP_WAIT == 4'd0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            // a dropped request abandons the transfer
            if (!w_req) begin
               w_next = S_IDLE;
            end else if (r_cnt <= 4'd1) begin
               w_next = S_ACK;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_ACK: begin
            w_wait = 1'b0;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_op_wr <= 1'b0;
      end else if (w_latch) begin
         r_addr  <= bus.address;
         r_wdata <= bus.writedata;
         r_op_wr <= bus.write;
      end
   end

   always_comb begin
      w_mapped = 1'b0;
      w_rmux   = '0;
      unique case (r_addr)
         A_REV: w_rmux = REV_ID;
         A_CMD: begin
            w_mapped = 1'b1;
            w_rmux   = r_cmd;
         end
         A_FRM: begin
            w_mapped = 1'b1;
            w_rmux   = {16'd0, r_frm};
         end
         A_THR: begin
            w_mapped = 1'b1;
            w_rmux   = {28'd0, r_thr};
         end
         A_PCS: begin
            w_mapped = 1'b1;
            w_rmux   = {29'd0, r_pcs};
         end
         default: begin
            w_mapped = 1'b0;
            w_rmux   = '0;
         end
      endcase
   end

   assign w_commit = (r_state == S_ACK) && r_op_wr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmd   <= '0;
         r_frm   <= FRM_LEN_RST;
         r_thr   <= '0;
         r_pcs   <= '0;
         r_flags <= '0;
         r_upd   <= 1'b0;
         r_init  <= 1'b0;
      end else begin
         r_upd  <= w_commit && w_mapped;
         r_init <= r_init | (&r_flags);
         if (w_commit) begin
            unique case (r_addr)
               A_CMD: begin
                  r_cmd      <= r_wdata;
                  r_flags[0] <= 1'b1;
               end
               A_FRM: r_frm <= r_wdata[15:0];
               A_THR: begin
                  r_thr      <= r_wdata[3:0];
                  r_flags[1] <= 1'b1;
               end
               A_PCS: begin
                  r_pcs      <= r_wdata[2:0];
                  r_flags[2] <= 1'b1;
               end
               default: r_flags <= r_flags;
            endcase
         end
      end
   end

   assign bus.waitrequest = w_wait;
   assign bus.readdata    = ((r_state == S_ACK) && !r_op_wr) ? w_rmux : '0;

   assign cfg_command    = r_cmd;
   assign cfg_frm_length = r_frm;
   assign cfg_fifo_thr   = r_thr;
   assign cfg_pcs_ctrl   = r_pcs;
   assign cfg_update     = r_upd;
   assign init_done      = r_init;

endmodule

// File: doc/mac_cfg_slave.md
Name: mac_cfg_slave

Overview:
- Avalon-MM slave model of the MAC control register bank; sits directly downstream of the MAC register-init master in the IPE_IF_OPENFLOW pipeline.
- Accepts the master's read/write transfers with a programmable waitrequest stall, holds the configuration registers and exports their fields to the MAC datapath.
- Raises a sticky `init_done` once all three boot-time registers (0x02, 0x0E, 0x94) have been written.

Parameters:
- WAIT_CYCLES, 2: stall cycles (waitrequest held high) after a request is seen, before the acknowledge cycle; legal range 0..15.
- FRM_LEN_RST, 1518: reset value of the frm_length register.
- REV_ID, 32'h0000_0901: constant returned at address 0x00.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- address  in  8  register word address
- write  in  1  write request
- read  in  1  read request
- writedata  in  32  write data
- readdata  out  32  read data, valid in the acknowledge cycle
- waitrequest  out  1  high = transfer not accepted
- cfg_command  out  32  command_config register (0x02)
- cfg_frm_length  out  16  frm_length[15:0] (0x05)
- cfg_fifo_thr  out  4  fifo threshold (0x0E[3:0])
- cfg_pcs_ctrl  out  3  PCS control (0x94[2:0])
- cfg_update  out  1  one-cycle pulse on any committed write to a mapped register
- init_done  out  1  sticky; high once 0x02, 0x0E and 0x94 have each been written

Behaviour:
- Reset (async, reset=0):
  - waitrequest=1, readdata=0, cfg_command=0, cfg_frm_length=FRM_LEN_RST, cfg_fifo_thr=0, cfg_pcs_ctrl=0, cfg_update=0, init_done=0.
  - Written-flags, stall counter and FSM are cleared; FSM enters IDLE.
  - Reset mid-transfer discards the transfer; no commit.
- Register map:
  - 0x00 REV_ID, read-only.
  - 0x02 command_config, 32 bits.
  - 0x05 frm_length, 16 bits; upper bits read 0.
  - 0x0E fifo_thr, 4 bits.
  - 0x94 pcs_ctrl, 3 bits.
  - Unmapped addresses: writes are ignored (no cfg_update); reads return 0.
  - Writes to 0x00 are ignored.
- FSM states: IDLE, WAIT, ACK. waitrequest is 1 in every state except ACK.
  - IDLE:
    - If write|read: latch address, writedata and op (write has priority if both are high).
    - Load counter=WAIT_CYCLES.
    - Go to WAIT, or to ACK if WAIT_CYCLES=0.
  - WAIT:
    - Decrement the counter; go to ACK when it reaches 1.
    - If write and read are both low this cycle, abort to IDLE with no commit.
  - ACK:
    - waitrequest=0 for exactly one cycle.
    - Write: commit to the latched register. The mapped register is updated on the clock edge that ends ACK and is visible from the next cycle; cfg_update pulses that same next cycle. Set the written-flag for 0x02, 0x0E or 0x94.
    - Read: readdata = latched register value during ACK; readdata returns to 0 the next cycle.
    - Always return to IDLE.
- Latency: a request sampled in IDLE completes after WAIT_CYCLES+1 cycles of waitrequest, on the ACK cycle.
- Request still high in the first IDLE cycle after ACK (the upstream master holds write one extra cycle):
  - It is treated as a new transfer and enters WAIT.
  - Because the master drops write on the next cycle, that transfer aborts, and a back-to-back repeated write is never double-committed unless the request is held through ACK.
- init_done = AND of the three written-flags, registered. It stays high until reset, including across later rewrites.
- Address/data changes during WAIT are ignored; the values latched in IDLE are used.

Test Plan:
- Reset: hold reset=0 for 5 cycles -> waitrequest=1, cfg_frm_length=1518, all other cfg outputs=0, init_done=0.
- Write 0x02=32'h0100_0093 with WAIT_CYCLES=2 -> waitrequest low exactly on the 3rd cycle after the request; cfg_command=32'h0100_0093 and cfg_update=1 on the following cycle.
- Init sequence: 0x02=32'h0100_0093, 0x0E=4, 0x94=7, each with write held one extra cycle after ack -> cfg_fifo_thr=4, cfg_pcs_ctrl=7, init_done rises after the third commit, exactly 3 cfg_update pulses.
- Reads: read 0x00 -> readdata=32'h0000_0901 in the ACK cycle. Read 0x40 (unmapped) -> readdata=0. Write 0x40=32'hFFFF_FFFF -> no cfg_update.
- Abort and priority: assert write to 0x05, drop it during WAIT -> no commit, frm_length stays 1518. Assert read and write together to 0x05 with data 9000 -> write wins, cfg_frm_length=9000.
- Reset mid-transfer: reset=0 during WAIT of a write to 0x94 -> cfg_pcs_ctrl=0, FSM in IDLE, init_done=0.
